// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave
// Description : AXI-lite style memory responder. Independent read and write
//               channel FSMs share one word-addressed array with programmable
//               read/write latencies and a sticky out-of-range address flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(64'h8000_0000),
    parameter int                    RD_LATENCY  = 2,
    parameter int                    WR_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   AR_ADDR,
    input  logic                    AR_VALID,
    output logic                    AR_READY,
    output logic [DATA_WIDTH-1:0]   R_DATA,
    output logic                    R_VALID,
    input  logic                    R_READY,
    input  logic [ADDR_WIDTH-1:0]   AW_ADDR,
    input  logic                    AW_VALID,
    output logic                    AW_READY,
    input  logic [DATA_WIDTH-1:0]   W_DATA,
    input  logic [DATA_WIDTH/8-1:0] W_STRB,
    input  logic                    W_VALID,
    output logic                    W_READY,
    output logic                    B_VALID,
    input  logic                    B_READY,
    output logic                    addr_err
);

    localparam int                    c_STRB_W = DATA_WIDTH / 8;
    localparam int                    c_SHIFT  = $clog2(c_STRB_W);
    localparam int                    c_IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_DEPTH  = ADDR_WIDTH'(DEPTH_WORDS);
    localparam logic [3:0]            c_RD_LAT = 4'(RD_LATENCY);
    localparam logic [3:0]            c_WR_LAT = 4'(WR_LATENCY);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // Address below the base wraps on subtraction, so the lower bound is checked explicitly.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> c_SHIFT) < c_DEPTH);
    endfunction

    function automatic logic [c_IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return c_IDX_W'((a - BASE_ADDR) >> c_SHIFT);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    // ------------------------------------------------------------------ read
    logic [1:0]            r_rd_state;
    logic [3:0]            r_rd_cnt;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  w_ar_hs;
    logic                  w_rd_fire;
    logic [ADDR_WIDTH-1:0] w_rd_sel_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // The sample cycle is the one before R_VALID rises; with latency 1 that is
    // the AR handshake cycle itself, so the live address is used there.
    assign w_ar_hs       = AR_VALID && AR_READY;
    assign w_rd_fire     = ((r_rd_state == R_IDLE) && w_ar_hs && (c_RD_LAT == 4'd1)) ||
                           ((r_rd_state == R_WAIT) && (r_rd_cnt == 4'd1));
    assign w_rd_sel_addr = (r_rd_state == R_IDLE) ? AR_ADDR : r_rd_addr;
    assign w_rd_data     = addr_in_range(w_rd_sel_addr) ? r_mem[addr_index(w_rd_sel_addr)]
                                                        : '0;

    // Read channel FSM: accept AR, wait out the latency, hold R until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rd_cnt   <= 4'd0;
            r_rd_addr  <= '0;
            AR_READY   <= 1'b0;
            R_VALID    <= 1'b0;
            R_DATA     <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rd_addr <= AR_ADDR;
                        AR_READY  <= 1'b0;
                        if (w_rd_fire) begin
                            R_DATA     <= w_rd_data;
                            R_VALID    <= 1'b1;
                            r_rd_state <= R_RESP;
                        end else begin
                            r_rd_cnt   <= c_RD_LAT - 4'd1;
                            r_rd_state <= R_WAIT;
                        end
                    end else begin
                        AR_READY <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (w_rd_fire) begin
                        R_DATA     <= w_rd_data;
                        R_VALID    <= 1'b1;
                        r_rd_state <= R_RESP;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (R_READY) begin
                        R_VALID    <= 1'b0;
                        AR_READY   <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------------- write
    logic [1:0]            r_wr_state;
    logic [3:0]            r_wr_cnt;
    logic                  r_aw_got;
    logic                  r_w_got;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [c_STRB_W-1:0]   r_wr_strb;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_have;
    logic                  w_w_have;
    logic                  w_wr_fire;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [c_STRB_W-1:0]   w_wr_strb;

    // Captured values take priority; a same-cycle handshake supplies the rest.
    assign w_aw_hs   = AW_VALID && AW_READY;
    assign w_w_hs    = W_VALID && W_READY;
    assign w_aw_have = r_aw_got || w_aw_hs;
    assign w_w_have  = r_w_got || w_w_hs;
    assign w_wr_addr = r_aw_got ? r_wr_addr : AW_ADDR;
    assign w_wr_data = r_w_got  ? r_wr_data : W_DATA;
    assign w_wr_strb = r_w_got  ? r_wr_strb : W_STRB;
    assign w_wr_fire = ((r_wr_state == W_IDLE) && w_aw_have && w_w_have && (c_WR_LAT == 4'd1)) ||
                       ((r_wr_state == W_WAIT) && (r_wr_cnt == 4'd1));

    // Write channel FSM: collect AW and W in any order, wait, then respond on B.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_wr_cnt   <= 4'd0;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_strb  <= '0;
            AW_READY   <= 1'b0;
            W_READY    <= 1'b0;
            B_VALID    <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wr_addr <= AW_ADDR;
                        r_aw_got  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wr_data <= W_DATA;
                        r_wr_strb <= W_STRB;
                        r_w_got   <= 1'b1;
                    end
                    AW_READY <= !w_aw_have;
                    W_READY  <= !w_w_have;
                    if (w_aw_have && w_w_have) begin
                        if (w_wr_fire) begin
                            B_VALID    <= 1'b1;
                            r_wr_state <= W_RESP;
                        end else begin
                            r_wr_cnt   <= c_WR_LAT - 4'd1;
                            r_wr_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_wr_fire) begin
                        B_VALID    <= 1'b1;
                        r_wr_state <= W_RESP;
                    end else begin
                        r_wr_cnt <= r_wr_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (B_READY) begin
                        B_VALID    <= 1'b0;
                        AW_READY   <= 1'b1;
                        W_READY    <= 1'b1;
                        r_aw_got   <= 1'b0;
                        r_w_got    <= 1'b0;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    // Byte-masked commit; reset in the commit cycle drops the write.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_fire && addr_in_range(w_wr_addr)) begin
            for (int i = 0; i < c_STRB_W; i++) begin
                if (w_wr_strb[i]) begin
                    r_mem[addr_index(w_wr_addr)][i*8 +: 8] <= w_wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Sticky error flag for any accepted out-of-range read or write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if ((w_ar_hs && !addr_in_range(AR_ADDR)) ||
                     (w_aw_hs && !addr_in_range(AW_ADDR))) begin
            addr_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
